led_pattern_decoder: RTL

LED_PATTERN_DECODER -- requirements
Module: led_pattern_decoder

---
 rtl/led_pattern_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_decoder.sv
// Recognises which of four walking-LED patterns is driving an 8-bit LED word, locks onto it
// after LOCK_CNT consecutive legal steps and flags frozen or illegal patterns.
module led_pattern_decoder #(
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] led,
  output logic [1:0] mode_det,
  output logic       locked,
  output logic       running,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

  localparam logic [2:0] LockCnt    = 3'(LOCK_CNT);
  localparam logic [7:0] StallLimit = 8'(STALL_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] prev_q;
  logic [1:0] cand_q, cand_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] stall_q, stall_d;
  logic [1:0] mode_q, mode_d;
  logic       locked_q, locked_d;
  logic       running_q, running_d;
  logic       err_q, err_d;

  logic       is_trans;
  logic       is_onehot;
  logic       legal_val;
  logic [3:0] match;
  logic       any_match;
  logic [1:0] match_mode;

  // Successor of p under mode m; zero when p is not on that mode's cycle.
  function automatic logic [7:0] next_of(input logic [1:0] m, input logic [7:0] p);
    logic       p_onehot;
    logic [7:0] nxt;
    p_onehot = (p != 8'h00) && ((p & (p - 8'h01)) == 8'h00);
    nxt      = 8'h00;
    case (m)
      2'd0: if (p_onehot) nxt = {p[0], p[7:1]};
      2'd1: if (p_onehot) nxt = {p[6:0], p[7]};
      2'd2: begin
        case (p)
          8'h18:   nxt = 8'h24;
          8'h24:   nxt = 8'h42;
          8'h42:   nxt = 8'h81;
          8'h81:   nxt = 8'h18;
          default: nxt = 8'h00;
        endcase
      end
      default: begin
        case (p)
          8'h81:   nxt = 8'h42;
          8'h42:   nxt = 8'h24;
          8'h24:   nxt = 8'h18;
          8'h18:   nxt = 8'h81;
          default: nxt = 8'h00;
        endcase
      end
    endcase
    return nxt;
  endfunction

  always_comb begin
    is_trans  = (led != prev_q);
    is_onehot = (led != 8'h00) && ((led & (led - 8'h01)) == 8'h00);
    legal_val = (led == 8'h00) || is_onehot || (led == 8'h18) || (led == 8'h24) ||
                (led == 8'h42) || (led == 8'h81);
    for (int m = 0; m < 4; m++) begin
      match[m] = (led != 8'h00) && (led == next_of(2'(m), prev_q));
    end
    any_match  = |match;
    match_mode = 2'd0;
    for (int m = 3; m >= 0; m--) begin
      if (match[m]) match_mode = 2'(m);
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = 1'b0;

    if (is_trans) begin
      stall_d = 8'h00;
    end else if ((state_q != StIdle) && (stall_q < StallLimit)) begin
      stall_d = stall_q + 8'h01;
    end else begin
      stall_d = stall_q;
    end

    if (led == 8'h00) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      stall_d = 8'h00;
    end else if (!legal_val) begin
      err_d   = 1'b1;
      state_d = StAcq;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StAcq;
          cnt_d   = 3'd0;
        end
        StAcq, StLock: begin
          // A step that continues the locked mode keeps the lock untouched.
          if (is_trans && !((state_q == StLock) && any_match && (match_mode == mode_q))) begin
            state_d = StAcq;
            if (!any_match) begin
              cnt_d = 3'd0;
            end else if (match_mode == cand_q) begin
              cnt_d = cnt_q + 3'd1;
            end else begin
              cand_d = match_mode;
              cnt_d  = 3'd1;
            end
            if (any_match && (cnt_d == LockCnt)) begin
              state_d = StLock;
              mode_d  = cand_d;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      endcase
    end

    locked_d  = (state_d == StLock);
    running_d = (state_d != StIdle) && (stall_d < StallLimit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      prev_q    <= 8'h00;
      cand_q    <= 2'd0;
      cnt_q     <= 3'd0;
      stall_q   <= 8'h00;
      mode_q    <= 2'd0;
      locked_q  <= 1'b0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= led;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      mode_q    <= mode_d;
      locked_q  <= locked_d;
      running_q <= running_d;
      err_q     <= err_d;
    end
  end

  assign mode_det = mode_q;
  assign locked   = locked_q;
  assign running  = running_q;
  assign err      = err_q;

endmodule
